// File: rtl/noc_pkg.sv
// Shared NoC definitions: node/payload widths and flit field offsets.
// Flit layout, MSB first: {dest, src, data}. Router and NI slice flits identically.
package noc_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int FLIT_W = 2 * ADDR_W + DATA_W;

    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = DATA_W - 1;
    localparam int SRC_LSB  = DATA_W;
    localparam int SRC_MSB  = DATA_W + ADDR_W - 1;
    localparam int DEST_LSB = DATA_W + ADDR_W;
    localparam int DEST_MSB = FLIT_W - 1;

    // Assemble a single-flit packet from its fields.
    function automatic logic [FLIT_W-1:0] pack_flit(input logic [ADDR_W-1:0] dest,
                                                    input logic [ADDR_W-1:0] src,
                                                    input logic [DATA_W-1:0] data);
        return {dest, src, data};
    endfunction

endpackage

// File: rtl/mips_network_interface_sync_fifo.sv
// Circular-buffer FIFO with registered count; full/empty decoded from the count.
// Push while full and pop while empty are ignored. Storage is cleared on reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Next-state: write at tail, advance pointers, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset drops all queued entries and clears storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_network_interface.sv
// Processor-side network interface: packs ni_out words into single-flit packets
// toward the router, and buffers addressed flits from the router for ni_in.
// Flits not addressed to this node are consumed, dropped and counted.
module mips_network_interface
    import noc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] current_node,
    input  logic              proc_valid,
    input  logic [ADDR_W-1:0] dest_add,
    input  logic [DATA_W-1:0] proc_data,
    output logic              mips_ni,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_to_proc,
    output logic [ADDR_W-1:0] src_to_proc,
    input  logic              proc_ready_in,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid_out,
    input  logic              router_ready_in,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_valid_in,
    output logic              ni_ready_out,
    output logic [7:0]        misroute_cnt
);

    localparam int RX_W = ADDR_W + DATA_W;

    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic              rx_accept, addr_hit;
    logic [RX_W-1:0]   rx_din, rx_dout;
    logic [7:0]        mis_q, mis_d;

    // TX path: processor -> router.
    assign mips_ni        = !tx_full;
    assign flit_valid_out = !tx_empty;
    assign tx_push        = proc_valid && mips_ni;
    assign tx_pop         = flit_valid_out && router_ready_in;

    sync_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (pack_flit(dest_add, current_node, proc_data)),
        .dout  (flit_out),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // RX path: router -> processor. Misrouted flits are still accepted so the
    // router is never stalled by a flit this node will never drain.
    assign ni_ready_out = !rx_full;
    assign rx_accept    = flit_valid_in && ni_ready_out;
    assign addr_hit     = (flit_in[DEST_MSB:DEST_LSB] == current_node);
    assign rx_push      = rx_accept && addr_hit;
    assign rx_din       = {flit_in[SRC_MSB:SRC_LSB], flit_in[DATA_MSB:DATA_LSB]};
    assign data_valid   = !rx_empty;
    assign rx_pop       = data_valid && proc_ready_in;
    assign src_to_proc  = rx_dout[RX_W-1:DATA_W];
    assign data_to_proc = rx_dout[DATA_W-1:0];

    sync_fifo #(.WIDTH(RX_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_din),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Saturating misroute counter.
    always_comb begin
        mis_d = mis_q;
        if (rx_accept && !addr_hit && (mis_q != 8'hFF)) mis_d = mis_q + 8'd1;
    end

    // Misroute counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= '0;
        else     mis_q <= mis_d;
    end

    assign misroute_cnt = mis_q;

endmodule

// File: tb/tb_mips_network_interface.sv
// Directed bench for mips_network_interface: a queue-based model tracks what
// each FIFO must hold and a negedge process compares every output against it;
// literal expectations at key points pin the model itself.
module tb_mips_network_interface;
    import noc_pkg::*;

    logic              clk = 0;
    logic              rst = 1;
    logic [ADDR_W-1:0] current_node = '0;
    logic              proc_valid = 0;
    logic [ADDR_W-1:0] dest_add = '0;
    logic [DATA_W-1:0] proc_data = '0;
    logic              mips_ni, data_valid, flit_valid_out, ni_ready_out;
    logic [DATA_W-1:0] data_to_proc;
    logic [ADDR_W-1:0] src_to_proc;
    logic              proc_ready_in = 0;
    logic [FLIT_W-1:0] flit_out;
    logic              router_ready_in = 0;
    logic [FLIT_W-1:0] flit_in = '0;
    logic              flit_valid_in = 0;
    logic [7:0]        misroute_cnt;

    int errors = 0;
    int checks = 0;

    mips_network_interface dut (
        .clk(clk), .rst(rst), .current_node(current_node),
        .proc_valid(proc_valid), .dest_add(dest_add), .proc_data(proc_data),
        .mips_ni(mips_ni), .data_valid(data_valid), .data_to_proc(data_to_proc),
        .src_to_proc(src_to_proc), .proc_ready_in(proc_ready_in),
        .flit_out(flit_out), .flit_valid_out(flit_valid_out),
        .router_ready_in(router_ready_in), .flit_in(flit_in),
        .flit_valid_in(flit_valid_in), .ni_ready_out(ni_ready_out),
        .misroute_cnt(misroute_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: two bounded queues and a saturating counter.
    logic [FLIT_W-1:0]        tx_q[$];
    logic [ADDR_W+DATA_W-1:0] rx_q[$];
    int                       mis = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            mis = 0;
        end else begin
            bit tx_acc, tx_pop, rx_acc, rx_pop;
            tx_acc = proc_valid && (tx_q.size() < 4);
            tx_pop = (tx_q.size() > 0) && router_ready_in;
            rx_acc = flit_valid_in && (rx_q.size() < 4);
            rx_pop = (rx_q.size() > 0) && proc_ready_in;
            if (tx_pop) void'(tx_q.pop_front());
            if (rx_pop) void'(rx_q.pop_front());
            if (tx_acc) tx_q.push_back({dest_add, current_node, proc_data});
            if (rx_acc) begin
                if (flit_in[FLIT_W-1 -: ADDR_W] == current_node)
                    rx_q.push_back(flit_in[ADDR_W+DATA_W-1:0]);
                else if (mis < 255)
                    mis++;
            end
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mips_ni", mips_ni, tx_q.size() < 4);
            chk("flit_valid_out", flit_valid_out, tx_q.size() > 0);
            if (tx_q.size() > 0) chk("flit_out", flit_out, tx_q[0]);
            chk("ni_ready_out", ni_ready_out, rx_q.size() < 4);
            chk("data_valid", data_valid, rx_q.size() > 0);
            if (rx_q.size() > 0) begin
                chk("data_to_proc", data_to_proc, rx_q[0][DATA_W-1:0]);
                chk("src_to_proc", src_to_proc, rx_q[0][ADDR_W+DATA_W-1:DATA_W]);
            end
            chk("misroute_cnt", misroute_cnt, mis);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mips_ni"}, mips_ni, 1);
        chk({tag, "_ni_ready"}, ni_ready_out, 1);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_flit_valid"}, flit_valid_out, 0);
        chk({tag, "_flit_out"}, flit_out, 0);
        chk({tag, "_data_to_proc"}, data_to_proc, 0);
        chk({tag, "_src_to_proc"}, src_to_proc, 0);
        chk({tag, "_misroute"}, misroute_cnt, 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_reset_vals("rst0");
        rst = 0;
        current_node = 2'd1;

        // Single TX word
        router_ready_in = 1;
        proc_valid = 1; dest_add = 2'd2; proc_data = 32'hDEADBEEF;
        tick();
        proc_valid = 0;
        chk("tx1_valid", flit_valid_out, 1);
        chk("tx1_flit", flit_out, 36'h9_DEADBEEF);
        tick();
        chk("tx1_popped", flit_valid_out, 0);

        // TX fill with router stalled
        router_ready_in = 0;
        for (int i = 0; i < 5; i++) begin
            proc_valid = 1; dest_add = 2'd3; proc_data = 32'h100 + i;
            tick();
            if (i == 2) chk("fill_mips_ni_3", mips_ni, 1);
        end
        proc_valid = 0;
        chk("fill_mips_ni_full", mips_ni, 0);
        chk("fill_head", flit_out, 36'hD_00000100);
        router_ready_in = 1;
        tick();
        chk("fill_mips_ni_after_pop", mips_ni, 1);
        chk("fill_head2", flit_out, 36'hD_00000101);
        tick(); tick(); tick();
        chk("fill_drained", flit_valid_out, 0);

        // RX addressed flit
        flit_in = {2'd1, 2'd3, 32'h12345678}; flit_valid_in = 1;
        tick();
        flit_valid_in = 0;
        chk("rx_valid", data_valid, 1);
        chk("rx_data", data_to_proc, 32'h12345678);
        chk("rx_src", src_to_proc, 3);
        proc_ready_in = 1;
        tick();
        proc_ready_in = 0;
        chk("rx_consumed", data_valid, 0);

        // Misrouted flood
        flit_in = {2'd0, 2'd2, 32'hCAFE0000}; flit_valid_in = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 9) chk("mis_10", misroute_cnt, 10);
        end
        flit_valid_in = 0;
        chk("mis_sat", misroute_cnt, 255);
        chk("mis_ready", ni_ready_out, 1);
        chk("mis_no_data", data_valid, 0);

        // Push/pop at count 2 across pointer wrap
        router_ready_in = 0;
        for (int i = 0; i < 2; i++) begin
            proc_valid = 1; dest_add = 2'd0; proc_data = 32'h1F0 + i;
            tick();
        end
        router_ready_in = 1;
        for (int i = 0; i < 10; i++) begin
            proc_valid = 1; dest_add = 2'd0; proc_data = 32'h200 + i;
            tick();
        end
        proc_valid = 0;
        chk("pp_head", flit_out, 36'h1_00000208);
        chk("pp_mips_ni", mips_ni, 1);
        tick(); tick();
        chk("pp_drained", flit_valid_out, 0);

        // Both FIFOs at 3, reset mid-cycle
        router_ready_in = 0;
        for (int i = 0; i < 3; i++) begin
            proc_valid = 1; dest_add = 2'd2; proc_data = 32'h300 + i;
            flit_in = {2'd1, 2'd2, 32'hA0 + i}; flit_valid_in = 1;
            tick();
        end
        proc_valid = 0; flit_valid_in = 0;
        chk("pre_rst_data", data_to_proc, 32'hA0);
        #2 rst = 1;
        #1 chk_reset_vals("rst_mid");
        tick();
        rst = 0;
        router_ready_in = 1; proc_ready_in = 1;
        tick(); tick();
        chk("post_rst_flit_valid", flit_valid_out, 0);
        chk("post_rst_data_valid", data_valid, 0);
        proc_ready_in = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_network_interface.md
Name: mips_network_interface

Overview:
- Processor-side network interface (NI) directly downstream of the MIPS control unit/datapath.
- Accepts ni_out transfers (proc_valid, dest_add, ALU result), packs each into a single-flit packet and queues it toward the local NoC router port.
- In the reverse direction, buffers flits arriving from the router and presents their payload to the processor for ni_in.
- Provides the mips_ni and data_valid handshakes that the control unit consumes.

Parameters:
- DATA_W, 32, payload width (ALU result / register-file word).
- ADDR_W, 2, node address width; 4 nodes.
- FIFO_DEPTH, 4, entries per TX and RX FIFO; power of 2, >= 2.
- FLIT_W, 2*ADDR_W+DATA_W, derived; flit = {dest, src, data}, MSB first.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- current_node  in  ADDR_W  this node's address; used as src field and RX address check.
- proc_valid  in  1  processor offers a word to send.
- dest_add  in  ADDR_W  destination node of offered word.
- proc_data  in  DATA_W  word to send (ALU output).
- mips_ni  out  1  NI can accept a word (TX not full).
- data_valid  out  1  RX word available to processor.
- data_to_proc  out  DATA_W  payload of RX head.
- src_to_proc  out  ADDR_W  source node of RX head.
- proc_ready_in  in  1  processor consumes RX head this cycle.
- flit_out  out  FLIT_W  TX head flit to router.
- flit_valid_out  out  1  flit_out valid.
- router_ready_in  in  1  router accepts flit_out.
- flit_in  in  FLIT_W  flit from router.
- flit_valid_in  in  1  flit_in valid.
- ni_ready_out  out  1  NI can accept flit_in (RX not full).
- misroute_cnt  out  8  saturating count of dropped flits whose dest != current_node.

Behaviour:
- Handshake rule, all four interfaces: transfer occurs on the rising edge where valid and ready are both 1. Valid must not depend combinationally on ready.
- TX push: proc_valid && mips_ni. Writes {dest_add, current_node, proc_data} at the tail.
- mips_ni = !tx_full, decoded from the registered count only.
- TX pop: flit_valid_out && router_ready_in.
- flit_valid_out = !tx_empty; flit_out = head entry.
- TX latency: a word pushed at edge N is on flit_out from edge N+1, if the FIFO was empty.
- RX push: flit_valid_in && ni_ready_out; ni_ready_out = !rx_full.
  - If flit_in dest field == current_node: write to RX FIFO.
  - Otherwise: flit is consumed (not back-pressured), discarded, and misroute_cnt increments, saturating at 255.
- RX pop: data_valid && proc_ready_in. data_valid = !rx_empty; data_to_proc/src_to_proc = head fields.
- RX latency: a flit accepted at edge N gives data_valid=1 from edge N+1.
- FIFOs: circular buffers, pointers of log2(FIFO_DEPTH) bits wrapping naturally, count of log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
  - Full: push blocked by ready=0 even if a pop occurs the same cycle (no pass-through).
  - Empty: pop impossible because valid=0; no bypass from input to output.
  - Pushes and pops outside the handshake are ignored; state is unchanged.
- Reset (async assert, any time including mid-transfer):
  - Pointers and counts cleared; all queued words lost.
  - misroute_cnt=0, mips_ni=1, ni_ready_out=1, data_valid=0, flit_valid_out=0.
  - flit_out, data_to_proc and src_to_proc read 0. Storage is cleared on reset.
- current_node may change only while both FIFOs are empty; otherwise behaviour is undefined.

Decomposition:
- Shared package noc_pkg holds ADDR_W and the flit field offsets (DEST_MSB/LSB, SRC_MSB/LSB, DATA_MSB/LSB). Router and NI use these same offsets.
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports push/pop/din/dout/full/empty), instantiated twice: TX with WIDTH=FLIT_W, RX with WIDTH=ADDR_W+DATA_W.
- Top level contains packing, address check, misroute counter and handshake glue.

Test Plan:
- Reset, then push proc_data=0xDEADBEEF, dest_add=2, current_node=1, router_ready_in=1 -> next cycle flit_valid_out=1, flit_out={2'b10,2'b01,0xDEADBEEF}; popped the following edge, flit_valid_out=0.
- router_ready_in=0, push 5 consecutive words -> mips_ni falls to 0 after the 4th; the 5th is held off. Raise router_ready_in -> 4 flits leave in order, and mips_ni=1 again after the first pop.
- flit_in dest=1, src=3, data=0x12345678 with current_node=1 -> data_valid=1 next cycle, data_to_proc=0x12345678, src_to_proc=3; proc_ready_in=1 -> data_valid=0 after that edge.
- 300 flits with dest=0 while current_node=1 -> ni_ready_out stays 1, data_valid stays 0, misroute_cnt saturates at 255.
- TX at count 2, push and pop on the same edge for 10 cycles -> count stays 2, order preserved across pointer wrap.
- Both FIFOs holding 3 entries, assert rst mid-cycle -> outputs immediately take reset values; after release, no stale flit or word appears.
